// File: rtl/reg_file_bist_if.sv
// Register file port bundle between the BIST master and the 2R/1W register file.
// The master drives the write port and both read addresses; the register file returns read data.
interface reg_file_bist_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] rf_waddr;
    logic                  rf_wen;
    logic [DATA_WIDTH-1:0] rf_wdata;
    logic [ADDR_WIDTH-1:0] rf_raddr1;
    logic [ADDR_WIDTH-1:0] rf_raddr2;
    logic [DATA_WIDTH-1:0] rf_rdata1;
    logic [DATA_WIDTH-1:0] rf_rdata2;

    modport master (
        output rf_waddr, rf_wen, rf_wdata, rf_raddr1, rf_raddr2,
        input  rf_rdata1, rf_rdata2
    );

    modport slave (
        input  rf_waddr, rf_wen, rf_wdata, rf_raddr1, rf_raddr2,
        output rf_rdata1, rf_rdata2
    );
endinterface

// File: rtl/reg_file_bist.sv
// Built-in self-test master for a 2-read/1-write register file: two write/read passes of an
// address-dependent pattern (true, then inverted), reporting the first failing address and data.
module reg_file_bist #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data,
    reg_file_bist_if.master       rf
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_WRITE = '1;
    localparam logic [ADDR_WIDTH-1:0] LAST_PAIR  = ADDR_WIDTH'(DEPTH - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE0,
        S_READ0,
        S_WRITE1,
        S_READ1,
        S_DONE
    } state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH-1:0] cnt, cnt_next, cnt_plus1;
    logic [DATA_WIDTH-1:0] seed_q;
    logic                  phase;
    logic [DATA_WIDTH-1:0] exp1, exp2;
    logic                  mis1, mis2;
    logic                  accept, finish_ok, capture_fail;

    function automatic logic [DATA_WIDTH-1:0] pattern(
        input logic [DATA_WIDTH-1:0] base_seed,
        input logic [ADDR_WIDTH-1:0] a,
        input logic                  inv
    );
        logic [DATA_WIDTH-1:0] base;
        base = base_seed + DATA_WIDTH'(a);
        return inv ? ~base : base;
    endfunction

    // Register 0 is hardwired to zero, so its readback expectation ignores the written pattern.
    function automatic logic [DATA_WIDTH-1:0] expected(
        input logic [DATA_WIDTH-1:0] base_seed,
        input logic [ADDR_WIDTH-1:0] a,
        input logic                  inv
    );
        return (a == '0) ? '0 : pattern(base_seed, a, inv);
    endfunction

    assign cnt_plus1 = cnt + 1'b1;
    assign phase     = (state == S_WRITE1) || (state == S_READ1);
    assign exp1      = expected(seed_q, cnt, phase);
    assign exp2      = expected(seed_q, cnt_plus1, phase);
    assign mis1      = (rf.rf_rdata1 != exp1);
    assign mis2      = (rf.rf_rdata2 != exp2);

    // busy/done decode the state register directly so an asynchronous reset clears them at once.
    assign busy = (state == S_WRITE0) || (state == S_READ0) ||
                  (state == S_WRITE1) || (state == S_READ1);
    assign done = (state == S_DONE);

    // NOTE: every signal driven here gets a default first, otherwise paths that skip it infer latches.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        accept        = 1'b0;
        finish_ok     = 1'b0;
        capture_fail  = 1'b0;
        rf.rf_wen     = 1'b0;
        rf.rf_waddr   = '0;
        rf.rf_wdata   = '0;
        rf.rf_raddr1  = '0;
        rf.rf_raddr2  = '0;

        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept     = 1'b1;
                    cnt_next   = '0;
                    state_next = S_WRITE0;
                end
            end
            S_WRITE0, S_WRITE1: begin
                rf.rf_wen   = 1'b1;
                rf.rf_waddr = cnt;
                rf.rf_wdata = pattern(seed_q, cnt, phase);
                cnt_next    = cnt + 1'b1;
                if (cnt == LAST_WRITE) begin
                    state_next = (state == S_WRITE0) ? S_READ0 : S_READ1;
                end
            end
            S_READ0, S_READ1: begin
                rf.rf_raddr1 = cnt;
                rf.rf_raddr2 = cnt_plus1;
                cnt_next     = cnt + ADDR_WIDTH'(2);
                if (mis1 || mis2) begin
                    capture_fail = 1'b1;
                    state_next   = S_DONE;
                end else if (cnt == LAST_PAIR) begin
                    cnt_next = '0;
                    if (state == S_READ0) begin
                        state_next = S_WRITE1;
                    end else begin
                        finish_ok  = 1'b1;
                        state_next = S_DONE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            seed_q    <= '0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                seed_q <= seed;
                pass   <= 1'b0;
            end
            if (finish_ok) begin
                pass <= 1'b1;
            end
            // Port 1 carries the lower address of the pair, so it wins when both mismatch.
            if (capture_fail) begin
                fail_addr <= mis1 ? cnt : cnt_plus1;
                fail_data <= mis1 ? rf.rf_rdata1 : rf.rf_rdata2;
            end
        end
    end

endmodule

// File: doc/reg_file_bist.md
Name: reg_file_bist

Overview:
- Built-in self-test master for the 2-read/1-write register file; it drives the register file's write and read ports directly.
- Writes a two-pass address-dependent pattern into every register, reads it back through both read ports, and reports pass/fail with the first failing address.
- Sits beside the CPU datapath. An external mux gives it the register file ports while busy is high.
- Register file contents are destroyed by a test run.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register address width; depth = 2**ADDR_WIDTH. Must be ≥1, so depth is even.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin test; sampled only in IDLE or DONE.
- seed  in  DATA_WIDTH  pattern seed; sampled at start.
- busy  out  1  test in progress; also the port-mux select.
- done  out  1  test finished; held until next accepted start.
- pass  out  1  valid while done; 1 = no mismatch.
- fail_addr  out  ADDR_WIDTH  first mismatching address; valid when done and !pass.
- fail_data  out  DATA_WIDTH  data read at fail_addr.
- rf_waddr  out  ADDR_WIDTH  register file write address.
- rf_wen  out  1  register file write enable.
- rf_wdata  out  DATA_WIDTH  register file write data.
- rf_raddr1  out  ADDR_WIDTH  read address, port 1.
- rf_raddr2  out  ADDR_WIDTH  read address, port 2.
- rf_rdata1  in  DATA_WIDTH  read data, port 1 (combinational in the register file).
- rf_rdata2  in  DATA_WIDTH  read data, port 2.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - busy, done, pass, rf_wen = 0.
  - fail_addr, fail_data, rf_waddr, rf_wdata, rf_raddr1, rf_raddr2 = 0.
  - Takes effect immediately, mid-test included; rf_wen must drop without waiting for a clock.
- States: IDLE, WRITE0, READ0, WRITE1, READ1, DONE.
- Internal registers: addr counter (ADDR_WIDTH), latched seed.
- Pattern:
  - E(a,0) = seed_latched + zero-extended a, modulo 2**DATA_WIDTH.
  - E(a,1) = ~E(a,0).
  - Expected readback at a = 0 is always 0, since register 0 is hardwired to zero.
- IDLE/DONE, start=1:
  - Latch seed, clear counter, clear done and pass.
  - Go to WRITE0; busy = 1 from that edge.
- WRITEp:
  - rf_wen = 1, rf_waddr = counter, rf_wdata = E(counter,p).
  - Counter increments each cycle.
  - After the cycle with counter = depth-1: counter wraps to 0, go to READp.
  - Duration: depth cycles.
- READp:
  - rf_wen = 0, rf_raddr1 = counter, rf_raddr2 = counter+1.
  - Compare rdata1 vs E(counter,p) and rdata2 vs E(counter+1,p) in the same cycle; counter steps by 2.
  - Duration: depth/2 cycles.
  - After the last pair with no mismatch: READ0→WRITE1, counter cleared; READ1→DONE with pass=1.
- Mismatch in READp:
  - Next edge → DONE, pass = 0.
  - fail_addr/fail_data take the port-1 address and data if port 1 mismatched, otherwise port 2.
  - Lower address wins when both ports mismatch.
  - Remaining reads are skipped.
- DONE: busy = 0, done = 1, results held.
- Output timing:
  - rf_* outputs are combinational decodes of state and counter registers only; they never depend on start.
  - rf_wen = 0 outside WRITE states.
  - Address outputs = 0 in IDLE and DONE.
- Latency, full pass: 3*depth busy cycles (96 at defaults). done rises on the edge after the last READ1 cycle.
- start while busy is ignored. start held high in DONE restarts on the next edge.
- Width rules: counter+1 is truncated to ADDR_WIDTH (never overflows, since counter is even in READ). Pattern addition wraps silently.

Test Plan:
- Ideal register file model, seed=0xA5A50000, start pulse → busy for exactly 96 cycles, then done=1, pass=1. Write trace shows addr 5 gets 0xA5A50005 in pass 0 and 0x5A5AFFFA in pass 1.
- Model with reg 7 bit 3 stuck at 1, seed=0 → pass 0 reads 0x0F at addr 7 (expected 0x07): done with pass=0, fail_addr=7, fail_data=0x0F. Busy ends 36 cycles after start (32 write cycles + 4 read pairs).
- Model corrupting both regs 12 and 13 → fail_addr=12, reporting port-1 data.
- Model that does not hardwire reg 0, seed=0x1234 → fail_addr=0, fail_data=0x1234 in READ0's first cycle.
- rst low mid-WRITE1 → rf_wen, busy, done drop asynchronously; after release, stays IDLE until start. Second run from DONE clears done/pass on the start edge and passes.
- start pulses during READ0 → ignored: run length and result unchanged, and seed changes after acceptance have no effect.
